apb_bank_arbiter: RTL and testbench
===================================

# apb_bank_arbiter

Two-master APB arbiter and transfer sequencer for the GPIO expander bank bus. It shares the bank-side APB port (psel/penable/pwrite/paddr/pwdata/prdata/pready) between master 0, the SPI-to-APB front end, and master 1, a local on-chip requester such as an input scanner. Each accepted request becomes one complete APB transfer. Arbitration is round-robin, illegal bank selects are rejected, and a stalled bank is aborted after a bounded wait.

## Interface
- BANK_ADDR, 2, number of banks; width of the one-hot bank select
- DATA_WIDTH, 8, APB data width
- ADDR_WIDTH, 3, APB register address width
- TIMEOUT, 15, maximum ACCESS cycles without pready before abort (≥2)

- pclk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- m0_req / m1_req  in  1  transfer request; held until done
- m0_write / m1_write  in  1  1=write, 0=read
- m0_sel / m1_sel  in  BANK_ADDR  one-hot bank select
- m0_addr / m1_addr  in  ADDR_WIDTH  register address
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  error flag, valid with done
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data, valid with done
- b_psel  out  BANK_ADDR  APB bank select (one-hot)
- b_penable  out  1  APB enable
- b_pwrite  out  1  APB direction
- b_paddr  out  ADDR_WIDTH  APB address
- b_pwdata  out  DATA_WIDTH  APB write data
- b_prdata  in  DATA_WIDTH  read data from the selected bank
- b_pready  in  1  ready from the selected bank
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE: sample m0_req and m1_req.
  - If exactly one is high, grant it.
  - If both are high, grant the master that was not granted last (rr pointer). After reset the pointer favours m0.
  - Latch the granted master's write, sel, addr and wdata into holding registers. Update the pointer.
  - Legal sel (exactly one bit set): go to SETUP.
  - Illegal sel (zero or more than one bit set): go straight to DONE with err=1 and rdata=0. No APB activity occurs.
- SETUP: b_psel=latched sel, b_penable=0; pwrite, paddr and pwdata driven from the latches. Go to ACCESS.
- ACCESS: b_penable=1 with psel, paddr, pwrite and pwdata held.
  - b_pready=1: capture b_prdata (reads only; writes return rdata=0). Go to DONE with err=0.
  - b_pready=0: increment the wait counter (width $clog2(TIMEOUT+1)). When the counter reaches TIMEOUT, abort: go to DONE with err=1 and rdata=0.
- DONE: the granted master's done pulses high for one cycle, with rdata and err. psel and penable are 0. Go to IDLE.
- Requester rule: a master drops req in the cycle after its done. A req still high in that IDLE cycle counts as a new transfer.
- When not in SETUP or ACCESS: b_psel=0, b_penable=0, b_pwrite=0, b_paddr=0, b_pwdata=0.
- The non-granted master's done, err and rdata stay 0 throughout.

## Timing
- Reset (synchronous, at a pclk edge):
  - State goes to IDLE and the rr pointer to m0.
  - All outputs are 0: done, err, rdata, b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, busy.
  - Reset mid-transfer abandons the transfer immediately. No done is issued.
- Zero-wait transfer (req sampled in cycle N): SETUP in N+1, ACCESS in N+2 with pready=1, done in N+3, IDLE in N+4. Latency from req to done is 3 cycles.
- Each wait state adds one cycle.
- Timeout: ACCESS lasts exactly TIMEOUT cycles, then DONE with err=1.
- Illegal sel: done with err=1 in N+1.
- Back-to-back: the earliest next SETUP is N+5. Worst-case wait for a continuously requesting master is one full transfer of the other master.
- b_pready and b_prdata are ignored outside ACCESS.
- Request fields are latched in IDLE. Changes after the grant do not affect the transfer in flight.

## Test plan
- Reset, then m0 writes sel=01, addr=5, wdata=A5 with pready tied 1 -> psel=01 in N+1, penable=1 in N+2, paddr=5, pwdata=A5, pwrite=1; m0_done=1, err=0, rdata=00 in N+3; all bus outputs 0 in N+3.
- m1 reads sel=10, addr=3; bank holds pready=0 for 2 ACCESS cycles, then drives prdata=3C with pready=1 -> m1_done in N+5 with rdata=3C, err=0; m0_done stays 0.
- m0 and m1 both request in the same cycle after reset, continuously for 4 transfers -> grant order m0, m1, m0, m1; psel matches each master's sel.
- Read with pready held 0, TIMEOUT=15 -> penable high for exactly 15 cycles, then done with err=1, rdata=00, then IDLE.
- sel=00 and sel=11 requests -> done with err=1 one cycle after the sample; psel stays 0.
- Reset asserted during ACCESS of a write -> the next cycle shows psel=0, penable=0, busy=0 and no done pulse; a new m1 request is then served normally.

Source files
------------

// File: rtl/apb_bank_arbiter_if.sv
// Bus bundle for the GPIO expander bank arbiter.
// It carries the two requester ports (m0, m1) and the shared bank-side APB port.
// The "slave" modport is the arbiter's view: it takes requests and drives the bank.
// The "master" modport is the view of the surrounding logic or a testbench.
interface apb_bank_arbiter_if #(
    parameter int BANK_ADDR  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) ();
    // requester 0 (SPI-to-APB front end)
    logic                  m0_req;
    logic                  m0_write;
    logic [BANK_ADDR-1:0]  m0_sel;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata;
    logic                  m0_done;
    logic                  m0_err;
    logic [DATA_WIDTH-1:0] m0_rdata;

    // requester 1 (local on-chip requester)
    logic                  m1_req;
    logic                  m1_write;
    logic [BANK_ADDR-1:0]  m1_sel;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata;
    logic                  m1_done;
    logic                  m1_err;
    logic [DATA_WIDTH-1:0] m1_rdata;

    // shared bank-side APB port
    logic [BANK_ADDR-1:0]  b_psel;
    logic                  b_penable;
    logic                  b_pwrite;
    logic [ADDR_WIDTH-1:0] b_paddr;
    logic [DATA_WIDTH-1:0] b_pwdata;
    logic [DATA_WIDTH-1:0] b_prdata;
    logic                  b_pready;

    modport slave (
        input  m0_req, m0_write, m0_sel, m0_addr, m0_wdata,
        output m0_done, m0_err, m0_rdata,
        input  m1_req, m1_write, m1_sel, m1_addr, m1_wdata,
        output m1_done, m1_err, m1_rdata,
        output b_psel, b_penable, b_pwrite, b_paddr, b_pwdata,
        input  b_prdata, b_pready
    );

    modport master (
        output m0_req, m0_write, m0_sel, m0_addr, m0_wdata,
        input  m0_done, m0_err, m0_rdata,
        output m1_req, m1_write, m1_sel, m1_addr, m1_wdata,
        input  m1_done, m1_err, m1_rdata,
        input  b_psel, b_penable, b_pwrite, b_paddr, b_pwdata,
        output b_prdata, b_pready
    );
endinterface

// File: rtl/apb_bank_arbiter.sv
// Two-master round-robin APB arbiter and transfer sequencer for the expander bank bus.
// Each granted request turns into exactly one SETUP/ACCESS transfer, or into an
// immediate error completion when the bank select is not one-hot.
// ACCESS is aborted with an error after TIMEOUT cycles without pready.
// Every output is a flop, loaded from the value that belongs to the next state.
module apb_bank_arbiter #(
    parameter int BANK_ADDR  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic                   pclk,
    input  logic                   reset,
    apb_bank_arbiter_if.slave      bus,
    output logic                   busy
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t                state, state_n;

    // grant / round-robin bookkeeping (gnt: 0 = m0, 1 = m1; rr_m1: prefer m1 on a tie)
    logic                  gnt, gnt_n;
    logic                  rr_m1, rr_m1_n;
    logic                  pick_m1;

    // request fields captured at grant time
    logic                  h_write, h_write_n;
    logic [BANK_ADDR-1:0]  h_sel, h_sel_n;
    logic [ADDR_WIDTH-1:0] h_addr, h_addr_n;
    logic [DATA_WIDTH-1:0] h_wdata, h_wdata_n;

    logic [CW-1:0]         cnt, cnt_n;

    // completion result produced by the transition into DONE
    logic                  rsp_err_n;
    logic [DATA_WIDTH-1:0] rsp_rdata_n;

    // output registers and their next values
    logic [BANK_ADDR-1:0]  psel_q, psel_n;
    logic                  penable_q, penable_n;
    logic                  pwrite_q, pwrite_n;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_n;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_n;
    logic                  done0_q, done0_n, done1_q, done1_n;
    logic                  err0_q, err0_n, err1_q, err1_n;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_n, rdata1_q, rdata1_n;
    logic                  busy_q, busy_n;

    // Next-state logic: arbitration and capture in IDLE, wait counting in ACCESS.
    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        rr_m1_n     = rr_m1;
        h_write_n   = h_write;
        h_sel_n     = h_sel;
        h_addr_n    = h_addr;
        h_wdata_n   = h_wdata;
        cnt_n       = cnt;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = '0;
        pick_m1     = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    // A lone requester always wins; on a tie the pointer decides.
                    pick_m1   = bus.m1_req && (!bus.m0_req || rr_m1);
                    gnt_n     = pick_m1;
                    rr_m1_n   = !pick_m1;
                    h_write_n = pick_m1 ? bus.m1_write : bus.m0_write;
                    h_sel_n   = pick_m1 ? bus.m1_sel   : bus.m0_sel;
                    h_addr_n  = pick_m1 ? bus.m1_addr  : bus.m0_addr;
                    h_wdata_n = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
                    if ($onehot(h_sel_n)) begin
                        state_n = S_SETUP;
                    end else begin
                        // No bank or several banks selected: fail without touching the bus.
                        state_n   = S_DONE;
                        rsp_err_n = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_n = S_ACCESS;
                cnt_n   = '0;
            end
            S_ACCESS: begin
                if (bus.b_pready) begin
                    state_n = S_DONE;
                    if (!h_write) rsp_rdata_n = bus.b_prdata;
                end else begin
                    cnt_n = cnt + CW'(1);
                    if (cnt_n == CW'(TIMEOUT)) begin
                        state_n   = S_DONE;
                        rsp_err_n = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Output next values, decoded from the state being entered.
    always_comb begin
        psel_n    = '0;
        penable_n = 1'b0;
        pwrite_n  = 1'b0;
        paddr_n   = '0;
        pwdata_n  = '0;
        done0_n   = 1'b0;
        done1_n   = 1'b0;
        err0_n    = 1'b0;
        err1_n    = 1'b0;
        rdata0_n  = '0;
        rdata1_n  = '0;
        busy_n    = (state_n != S_IDLE);

        if (state_n == S_SETUP || state_n == S_ACCESS) begin
            psel_n    = h_sel_n;
            penable_n = (state_n == S_ACCESS);
            pwrite_n  = h_write_n;
            paddr_n   = h_addr_n;
            pwdata_n  = h_wdata_n;
        end

        if (state_n == S_DONE) begin
            if (gnt_n) begin
                done1_n  = 1'b1;
                err1_n   = rsp_err_n;
                rdata1_n = rsp_rdata_n;
            end else begin
                done0_n  = 1'b1;
                err0_n   = rsp_err_n;
                rdata0_n = rsp_rdata_n;
            end
        end
    end

    // State, holding and output registers; reset drops any transfer in flight.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state     <= S_IDLE;
            gnt       <= 1'b0;
            rr_m1     <= 1'b0;
            h_write   <= 1'b0;
            h_sel     <= '0;
            h_addr    <= '0;
            h_wdata   <= '0;
            cnt       <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            rr_m1     <= rr_m1_n;
            h_write   <= h_write_n;
            h_sel     <= h_sel_n;
            h_addr    <= h_addr_n;
            h_wdata   <= h_wdata_n;
            cnt       <= cnt_n;
            psel_q    <= psel_n;
            penable_q <= penable_n;
            pwrite_q  <= pwrite_n;
            paddr_q   <= paddr_n;
            pwdata_q  <= pwdata_n;
            done0_q   <= done0_n;
            done1_q   <= done1_n;
            err0_q    <= err0_n;
            err1_q    <= err1_n;
            rdata0_q  <= rdata0_n;
            rdata1_q  <= rdata1_n;
            busy_q    <= busy_n;
        end
    end

    assign bus.b_psel    = psel_q;
    assign bus.b_penable = penable_q;
    assign bus.b_pwrite  = pwrite_q;
    assign bus.b_paddr   = paddr_q;
    assign bus.b_pwdata  = pwdata_q;
    assign bus.m0_done   = done0_q;
    assign bus.m0_err    = err0_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_done   = done1_q;
    assign bus.m1_err    = err1_q;
    assign bus.m1_rdata  = rdata1_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_apb_bank_arbiter.sv
// Directed bench for apb_bank_arbiter: reset, single transfers, wait states,
// round-robin order, timeout, illegal selects and reset during ACCESS.
module tb_apb_bank_arbiter;
    logic pclk;
    logic reset;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;

    apb_bank_arbiter_if #(.BANK_ADDR(2), .DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    apb_bank_arbiter #(.BANK_ADDR(2), .DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(15)) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.m0_req   = 1'b0; bus.m0_write = 1'b0; bus.m0_sel = 2'b00; bus.m0_addr = 3'd0; bus.m0_wdata = 8'h00;
        bus.m1_req   = 1'b0; bus.m1_write = 1'b0; bus.m1_sel = 2'b00; bus.m1_addr = 3'd0; bus.m1_wdata = 8'h00;
        bus.b_prdata = 8'h00;
        bus.b_pready = 1'b0;

        // ---- reset state
        tick(); tick();
        chk("rst_psel",    32'(bus.b_psel), 0);
        chk("rst_bus",     32'({bus.b_penable, bus.b_pwrite, bus.b_paddr, bus.b_pwdata}), 0);
        chk("rst_done",    32'({bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err}), 0);
        chk("rst_rdata",   32'({bus.m0_rdata, bus.m1_rdata}), 0);
        chk("rst_busy",    32'(busy), 0);
        reset = 1'b0;
        tick();

        // ---- m0 zero-wait write, sel=01 addr=5 wdata=A5 (prdata noise must be ignored)
        bus.b_pready = 1'b1; bus.b_prdata = 8'hEE;
        bus.m0_write = 1'b1; bus.m0_sel = 2'b01; bus.m0_addr = 3'd5; bus.m0_wdata = 8'hA5; bus.m0_req = 1'b1;
        tick(); // N+1 SETUP
        chk("wr_setup_psel",    32'(bus.b_psel), 32'h1);
        chk("wr_setup_penable", 32'(bus.b_penable), 0);
        chk("wr_setup_pwrite",  32'(bus.b_pwrite), 1);
        chk("wr_setup_paddr",   32'(bus.b_paddr), 5);
        chk("wr_setup_pwdata",  32'(bus.b_pwdata), 32'hA5);
        chk("wr_setup_busy",    32'(busy), 1);
        tick(); // N+2 ACCESS
        chk("wr_acc_penable",   32'(bus.b_penable), 1);
        chk("wr_acc_psel",      32'(bus.b_psel), 32'h1);
        chk("wr_acc_addr_data", 32'({bus.b_paddr, bus.b_pwdata}), 32'h5A5);
        tick(); // N+3 DONE
        chk("wr_done0",         32'(bus.m0_done), 1);
        chk("wr_err0",          32'(bus.m0_err), 0);
        chk("wr_rdata0",        32'(bus.m0_rdata), 0);
        chk("wr_done1_quiet",   32'(bus.m1_done), 0);
        chk("wr_done_bus_idle", 32'({bus.b_psel, bus.b_penable, bus.b_pwrite, bus.b_paddr, bus.b_pwdata}), 0);
        bus.m0_req = 1'b0;
        tick(); // N+4 IDLE
        chk("wr_idle_busy",     32'(busy), 0);
        chk("wr_idle_done0",    32'(bus.m0_done), 0);

        // ---- m1 read sel=10 addr=3 with two wait states, then prdata=3C
        bus.b_pready = 1'b0; bus.b_prdata = 8'h77;
        bus.m1_write = 1'b0; bus.m1_sel = 2'b10; bus.m1_addr = 3'd3; bus.m1_wdata = 8'h99; bus.m1_req = 1'b1;
        tick(); // N+1 SETUP
        chk("rd_setup_psel",    32'(bus.b_psel), 32'h2);
        chk("rd_setup_pwrite",  32'(bus.b_pwrite), 0);
        chk("rd_setup_paddr",   32'(bus.b_paddr), 3);
        tick(); // N+2 ACCESS wait 1
        chk("rd_wait1_penable", 32'(bus.b_penable), 1);
        tick(); // N+3 ACCESS wait 2
        chk("rd_wait2_penable", 32'(bus.b_penable), 1);
        chk("rd_wait2_done1",   32'(bus.m1_done), 0);
        tick(); // N+4 ACCESS, bank ready
        chk("rd_acc3_penable",  32'(bus.b_penable), 1);
        bus.b_pready = 1'b1; bus.b_prdata = 8'h3C;
        tick(); // N+5 DONE
        chk("rd_done1",         32'(bus.m1_done), 1);
        chk("rd_rdata1",        32'(bus.m1_rdata), 32'h3C);
        chk("rd_err1",          32'(bus.m1_err), 0);
        chk("rd_done0_quiet",   32'({bus.m0_done, bus.m0_err, bus.m0_rdata}), 0);
        bus.m1_req = 1'b0; bus.b_prdata = 8'h00;
        tick();
        chk("rd_idle_busy",     32'(busy), 0);

        // ---- round robin: fresh reset, both masters requesting continuously
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.b_pready = 1'b1;
        bus.m0_write = 1'b1; bus.m0_sel = 2'b01; bus.m0_addr = 3'd1; bus.m0_wdata = 8'h11;
        bus.m1_write = 1'b1; bus.m1_sel = 2'b10; bus.m1_addr = 3'd2; bus.m1_wdata = 8'h22;
        bus.m0_req = 1'b1; bus.m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); // SETUP
            chk($sformatf("rr%0d_psel", k),  32'(bus.b_psel), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk($sformatf("rr%0d_paddr", k), 32'(bus.b_paddr), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick(); // ACCESS
            chk($sformatf("rr%0d_pwdata", k), 32'(bus.b_pwdata), (k % 2 == 0) ? 32'h11 : 32'h22);
            tick(); // DONE
            chk($sformatf("rr%0d_done", k), 32'({bus.m1_done, bus.m0_done}), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k == 3) begin
                bus.m0_req = 1'b0; bus.m1_req = 1'b0;
            end
            tick(); // IDLE
        end
        chk("rr_end_busy", 32'(busy), 0);

        // ---- timeout: m0 read with pready held low
        bus.b_pready = 1'b0; bus.b_prdata = 8'h5A;
        bus.m0_write = 1'b0; bus.m0_sel = 2'b01; bus.m0_addr = 3'd7; bus.m0_req = 1'b1;
        tick(); // SETUP
        chk("to_setup_penable", 32'(bus.b_penable), 0);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("to_acc%0d", i), 32'({bus.b_penable, bus.m0_done}), 32'h2);
        end
        tick(); // DONE
        chk("to_done0",   32'(bus.m0_done), 1);
        chk("to_err0",    32'(bus.m0_err), 1);
        chk("to_rdata0",  32'(bus.m0_rdata), 0);
        chk("to_penable", 32'(bus.b_penable), 0);
        bus.m0_req = 1'b0;
        tick();
        chk("to_idle_busy", 32'(busy), 0);

        // ---- illegal selects: m1 sel=00, then m0 sel=11
        bus.b_pready = 1'b1;
        bus.m1_write = 1'b1; bus.m1_sel = 2'b00; bus.m1_req = 1'b1;
        tick();
        chk("ill00_done_err", 32'({bus.m1_done, bus.m1_err}), 32'h3);
        chk("ill00_rdata",    32'(bus.m1_rdata), 0);
        chk("ill00_psel",     32'({bus.b_psel, bus.b_penable}), 0);
        bus.m1_req = 1'b0;
        tick();
        chk("ill00_idle", 32'({busy, bus.m1_done}), 0);
        bus.m0_write = 1'b0; bus.m0_sel = 2'b11; bus.m0_req = 1'b1;
        tick();
        chk("ill11_done_err", 32'({bus.m0_done, bus.m0_err}), 32'h3);
        chk("ill11_psel",     32'({bus.b_psel, bus.b_penable}), 0);
        chk("ill11_m1_quiet", 32'(bus.m1_done), 0);
        bus.m0_req = 1'b0;
        tick();

        // ---- reset during ACCESS of a write, then a normal m1 read
        bus.b_pready = 1'b0;
        bus.m0_write = 1'b1; bus.m0_sel = 2'b10; bus.m0_addr = 3'd4; bus.m0_wdata = 8'hC3; bus.m0_req = 1'b1;
        tick(); // SETUP
        tick(); // ACCESS
        chk("rsta_penable", 32'(bus.b_penable), 1);
        reset = 1'b1; bus.m0_req = 1'b0;
        tick();
        chk("rsta_bus",  32'({bus.b_psel, bus.b_penable}), 0);
        chk("rsta_busy", 32'(busy), 0);
        chk("rsta_done", 32'({bus.m0_done, bus.m1_done}), 0);
        reset = 1'b0;
        tick();
        chk("rsta_nodone", 32'({bus.m0_done, bus.m1_done, busy}), 0);
        bus.b_pready = 1'b1; bus.b_prdata = 8'h5A;
        bus.m1_write = 1'b0; bus.m1_sel = 2'b01; bus.m1_addr = 3'd6; bus.m1_req = 1'b1;
        tick(); // SETUP
        chk("post_psel", 32'({bus.b_psel, bus.b_paddr}), 32'h0E);
        tick(); // ACCESS
        tick(); // DONE
        chk("post_done1", 32'({bus.m1_done, bus.m1_err}), 32'h2);
        chk("post_rdata", 32'(bus.m1_rdata), 32'h5A);
        bus.m1_req = 1'b0;
        tick();
        chk("post_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
